// File: rtl/numero_bcd_display.sv
// Converts a 14-bit binary value into four BCD digits by shift-add-3, one bit per clock.
// It also drives four registered active-low 7-segment patterns, with optional leading-zero blanking.
module numero_bcd_display #(
    parameter bit BLANK_ZEROS = 1'b0,
    parameter int MAX_VALUE   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] numero,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [0:6]  hex3,
    output logic [0:6]  hex2,
    output logic [0:6]  hex1,
    output logic [0:6]  hex0
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_ZERO  = 7'b0000001;

    logic [0:0]        state_reg;
    logic [13:0]       bin_reg;
    logic [15:0]       bcd_reg;
    logic [3:0]        count_reg;
    logic              ovf_pend_reg;
    logic              overflow_reg;
    logic              done_reg;
    logic [3:0][3:0]   digit_reg;
    logic [3:0][0:6]   hex_reg;

    logic [15:0]       bcd_adj;
    logic [29:0]       shift_next;
    logic              ovf_in;
    logic [3:0][3:0]   final_digit;
    logic [3:0]        lead_zero;
    logic [3:0][0:6]   hex_next;
    logic [3:0][0:6]   hex_reset;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b1100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0001100;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    assign ovf_in = int'(numero) > MAX_VALUE;

    // Each nibble is corrected independently; a carry out of a nibble is never propagated.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
            assign final_digit[gi] = ovf_pend_reg ? 4'hF : shift_next[14 + gi*4 +: 4];
        end
    endgenerate

    assign shift_next = {bcd_adj, bin_reg} << 1;

    // A digit is a leading zero when it and every more significant digit are zero.
    assign lead_zero[3] = (final_digit[3] == 4'd0);
    generate
        for (gi = 2; gi >= 0; gi--) begin : g_lead
            assign lead_zero[gi] = lead_zero[gi+1] && (final_digit[gi] == 4'd0);
        end
        for (gi = 0; gi < 4; gi++) begin : g_hex
            if (gi == 0) begin : g_units
                assign hex_next[gi]  = seg7(final_digit[gi]);
                assign hex_reset[gi] = SEG_ZERO;
            end else begin : g_upper
                assign hex_next[gi]  = (BLANK_ZEROS && lead_zero[gi]) ? SEG_BLANK
                                                                      : seg7(final_digit[gi]);
                assign hex_reset[gi] = BLANK_ZEROS ? SEG_BLANK : SEG_ZERO;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            count_reg    <= '0;
            ovf_pend_reg <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            digit_reg    <= '0;
            hex_reg      <= hex_reset;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg      <= numero;
                        bcd_reg      <= '0;
                        count_reg    <= '0;
                        ovf_pend_reg <= ovf_in;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    bcd_reg   <= shift_next[29:14];
                    bin_reg   <= shift_next[13:0];
                    count_reg <= count_reg + 4'd1;
                    if (count_reg == 4'd13) begin
                        digit_reg    <= final_digit;
                        hex_reg      <= hex_next;
                        overflow_reg <= ovf_pend_reg;
                        done_reg     <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == CONV);
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign digit3   = digit_reg[3];
    assign digit2   = digit_reg[2];
    assign digit1   = digit_reg[1];
    assign digit0   = digit_reg[0];
    assign hex3     = hex_reg[3];
    assign hex2     = hex_reg[2];
    assign hex1     = hex_reg[1];
    assign hex0     = hex_reg[0];

endmodule

// File: tb/tb_numero_bcd_display.sv
// Directed bench for numero_bcd_display: one instance without blanking (a), one with blanking (b),
// both driven by the same stimulus.
module tb_numero_bcd_display;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b1100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0001100, BL = 7'b1111111, DS = 7'b1111110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] numero = '0;

    logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [3:0] da3, da2, da1, da0, db3, db2, db1, db0;
    logic [0:6] ha3, ha2, ha1, ha0, hb3, hb2, hb1, hb0;

    int cmp_count = 0;
    int err_count = 0;

    wire [15:0] digs_a = {da3, da2, da1, da0};
    wire [15:0] digs_b = {db3, db2, db1, db0};
    wire [27:0] hexs_a = {ha3, ha2, ha1, ha0};
    wire [27:0] hexs_b = {hb3, hb2, hb1, hb0};

    always #5 clk = ~clk;

    numero_bcd_display #(.BLANK_ZEROS(1'b0), .MAX_VALUE(9999)) dut_a (
        .clk(clk), .reset(reset), .start(start), .numero(numero),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .digit3(da3), .digit2(da2), .digit1(da1), .digit0(da0),
        .hex3(ha3), .hex2(ha2), .hex1(ha1), .hex0(ha0)
    );

    numero_bcd_display #(.BLANK_ZEROS(1'b1), .MAX_VALUE(9999)) dut_b (
        .clk(clk), .reset(reset), .start(start), .numero(numero),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .digit3(db3), .digit2(db2), .digit1(db1), .digit0(db0),
        .hex3(hb3), .hex2(hb2), .hex1(hb1), .hex0(hb0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and waits (bounded) for done; lat counts edges after the start edge.
    task automatic start_and_wait(input logic [13:0] v, output int lat, output int busy_cnt);
        start = 1'b1;
        numero = v;
        step();
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done_a && lat < 40) begin
            if (busy_a) busy_cnt++;
            step();
            lat++;
        end
        $display("conv numero=%0d lat=%0d busy=%0d digits=%h ovf=%b", v, lat, busy_cnt, digs_a, ovf_a);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        cmp_count++;
        if ({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== 6'b0) begin
            err_count++;
            $display("FAIL reset_flags: got %b expected 000000", {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b});
        end
        cmp_count++;
        if (digs_a !== 16'h0000 || digs_b !== 16'h0000) begin
            err_count++;
            $display("FAIL reset_digits: got %h/%h expected 0000", digs_a, digs_b);
        end
        cmp_count++;
        if (hexs_a !== {S0, S0, S0, S0}) begin
            err_count++;
            $display("FAIL reset_hex_a: got %h expected %h", hexs_a, {S0, S0, S0, S0});
        end
        cmp_count++;
        if (hexs_b !== {BL, BL, BL, S0}) begin
            err_count++;
            $display("FAIL reset_hex_b: got %h expected %h", hexs_b, {BL, BL, BL, S0});
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        int lat, bc;
        start_and_wait(14'd1234, lat, bc);
        cmp_count++;
        if (lat !== 14 || bc !== 14) begin
            err_count++;
            $display("FAIL basic_latency: got lat=%0d busy=%0d expected 14/14", lat, bc);
        end
        cmp_count++;
        if (digs_a !== 16'h1234 || ovf_a !== 1'b0 || busy_a !== 1'b0) begin
            err_count++;
            $display("FAIL basic_digits: got %h ovf=%b busy=%b expected 1234 0 0", digs_a, ovf_a, busy_a);
        end
        cmp_count++;
        if (hexs_a !== {S1, S2, S3, S4} || hexs_b !== {S1, S2, S3, S4}) begin
            err_count++;
            $display("FAIL basic_hex: got %h/%h expected %h", hexs_a, hexs_b, {S1, S2, S3, S4});
        end
        step();
        cmp_count++;
        if (done_a !== 1'b0 || digs_a !== 16'h1234) begin
            err_count++;
            $display("FAIL basic_done_pulse: got done=%b digits=%h expected 0 1234", done_a, digs_a);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        start_and_wait(14'd9999, lat, bc);
        cmp_count++;
        if (digs_a !== 16'h9999 || hexs_a !== {S9, S9, S9, S9} || ovf_a !== 1'b0) begin
            err_count++;
            $display("FAIL b2b_first: got %h hex=%h ovf=%b expected 9999", digs_a, hexs_a, ovf_a);
        end
        start = 1'b1;
        numero = 14'd0;
        step();
        start = 1'b0;
        gap = 1;
        cmp_count++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            err_count++;
            $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done_a, busy_a);
        end
        while (!done_a && gap < 40) begin
            step();
            gap++;
        end
        $display("conv numero=0 gap=%0d digits=%h", gap, digs_a);
        cmp_count++;
        if (gap !== 15) begin
            err_count++;
            $display("FAIL b2b_gap: got %0d expected 15", gap);
        end
        cmp_count++;
        if (digs_a !== 16'h0000 || hexs_a !== {S0, S0, S0, S0} || hexs_b !== {BL, BL, BL, S0}) begin
            err_count++;
            $display("FAIL b2b_second: got %h hex=%h/%h expected 0000", digs_a, hexs_a, hexs_b);
        end
    endtask

    task automatic test_blanking();
        int lat, bc;
        start_and_wait(14'd7, lat, bc);
        cmp_count++;
        if (digs_b !== 16'h0007 || hexs_b !== {BL, BL, BL, S7} || hexs_a !== {S0, S0, S0, S7}) begin
            err_count++;
            $display("FAIL blank_7: got %h hex=%h/%h expected 0007", digs_b, hexs_a, hexs_b);
        end
        start_and_wait(14'd1000, lat, bc);
        cmp_count++;
        if (digs_b !== 16'h1000 || hexs_b !== {S1, S0, S0, S0}) begin
            err_count++;
            $display("FAIL blank_1000: got %h hex=%h expected 1000 %h", digs_b, hexs_b, {S1, S0, S0, S0});
        end
        start_and_wait(14'd105, lat, bc);
        cmp_count++;
        if (digs_b !== 16'h0105 || hexs_b !== {BL, S1, S0, S5}) begin
            err_count++;
            $display("FAIL blank_105: got %h hex=%h expected 0105 %h", digs_b, hexs_b, {BL, S1, S0, S5});
        end
    endtask

    task automatic test_ignore_start();
        int k;
        start = 1'b1;
        numero = 14'd5678;
        step();
        start = 1'b0;
        k = 0;
        while (!done_a && k < 40) begin
            if (k == 4) begin
                start = 1'b1;
                numero = 14'd4321;
            end else if (k == 5) begin
                start = 1'b0;
            end
            cmp_count++;
            if (digs_a !== 16'h0105) begin
                err_count++;
                $display("FAIL ignore_midconv_hold: got %h expected 0105 at k=%0d", digs_a, k);
            end
            step();
            k++;
        end
        $display("conv numero=5678 (start 4321 mid-run) lat=%0d digits=%h", k, digs_a);
        cmp_count++;
        if (k !== 14 || digs_a !== 16'h5678 || hexs_a !== {S5, S6, S7, S8}) begin
            err_count++;
            $display("FAIL ignore_result: got lat=%0d %h hex=%h expected 14 5678", k, digs_a, hexs_a);
        end
        step();
        cmp_count++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            err_count++;
            $display("FAIL ignore_noqueue: got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        start_and_wait(14'd10000, lat, bc);
        cmp_count++;
        if (lat !== 14 || ovf_a !== 1'b1 || ovf_b !== 1'b1 || digs_a !== 16'hFFFF) begin
            err_count++;
            $display("FAIL ovf_flag: got lat=%0d ovf=%b%b %h expected 14 11 FFFF", lat, ovf_a, ovf_b, digs_a);
        end
        cmp_count++;
        if (hexs_a !== {DS, DS, DS, DS} || hexs_b !== {DS, DS, DS, DS}) begin
            err_count++;
            $display("FAIL ovf_hex: got %h/%h expected %h", hexs_a, hexs_b, {DS, DS, DS, DS});
        end
        step();
        step();
        cmp_count++;
        if (ovf_a !== 1'b1) begin
            err_count++;
            $display("FAIL ovf_held: got %b expected 1", ovf_a);
        end
        start_and_wait(14'd42, lat, bc);
        cmp_count++;
        if (ovf_a !== 1'b0 || digs_a !== 16'h0042 || hexs_a !== {S0, S0, S4, S2} || hexs_b !== {BL, BL, S4, S2}) begin
            err_count++;
            $display("FAIL ovf_clear: got ovf=%b %h hex=%h/%h expected 0 0042", ovf_a, digs_a, hexs_a, hexs_b);
        end
    endtask

    task automatic test_reset_midconv();
        int lat, bc, dones;
        start_and_wait(14'd16383, lat, bc);
        start = 1'b1;
        numero = 14'd1234;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("reset at cycle 7 of numero=1234");
        cmp_count++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0 || digs_a !== 16'h0000) begin
            err_count++;
            $display("FAIL midreset_state: got busy=%b done=%b ovf=%b %h expected 0 0 0 0000", busy_a, done_a, ovf_a, digs_a);
        end
        cmp_count++;
        if (hexs_a !== {S0, S0, S0, S0} || hexs_b !== {BL, BL, BL, S0}) begin
            err_count++;
            $display("FAIL midreset_hex: got %h/%h expected reset patterns", hexs_a, hexs_b);
        end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_a || busy_a) dones++;
            step();
        end
        cmp_count++;
        if (dones !== 0) begin
            err_count++;
            $display("FAIL midreset_nodone: got %0d active cycles expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_blanking();
        test_ignore_start();
        test_overflow();
        test_reset_midconv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/numero_bcd_display.md
Name: numero_bcd_display

Overview:
- Output-side counterpart of the keypad entry path: takes a 14-bit binary value (0..9999) and converts it back into four BCD digits.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock.
- Registered digits drive four active-low 7-segment patterns (HEX3..HEX0).
- Sits between any binary producer (keypad accumulator, arithmetic result) and the board displays; start/busy/done handshake.

Parameters:
- BLANK_ZEROS, 0, when 1 leading-zero digits 3..1 show all segments off (7'b1111111); digit0 always shown.
- MAX_VALUE, 9999, largest accepted input; larger values flag overflow.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of numero; sampled only in IDLE
- numero  input  14  binary value to convert, latched on accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when digit/hex outputs have been updated
- overflow  output  1  latched input exceeded MAX_VALUE; valid with done, held until next done
- digit3, digit2, digit1, digit0  output  4 each  BCD digits, thousands..units, held between conversions
- hex3, hex2, hex1, hex0  output  [0:6] each  active-low segments, bit0=a(top) .. bit6=g(middle)

Behaviour:
- Reset (clk edge with reset=1, overrides everything incl. start): state=IDLE; busy=0, done=0, overflow=0; all digits=0; hex0=7'b0000001; hex3..hex1=7'b0000001 (BLANK_ZEROS=0) or 7'b1111111 (BLANK_ZEROS=1).
- States IDLE, CONV.
- IDLE, start=1 at edge N:
  - latch numero into 14-bit shift register; clear 16-bit BCD accumulator and 4-bit count; latch ovf_pend = (numero > MAX_VALUE).
  - state=CONV, busy=1 from N.
- IDLE, start=0: hold everything; done=0.
- CONV, each edge:
  - per BCD nibble: if nibble >= 5 add 3 (4-bit, no carry into next nibble); then shift {bcd, bin} left by 1; count++.
  - 14 edges total (N+1..N+14).
  - On the 14th edge (count==13 before increment):
    - ovf_pend=0: digits <= accumulator nibbles.
    - ovf_pend=1: digits <= 4'hF, all hex <= 7'b1111110 (dash).
    - overflow <= ovf_pend; done=1; busy=0; state=IDLE.
- Latency: done high in the cycle after edge N+14; digit/hex/overflow change only on that edge, never mid-conversion.
- Segment encoding (digit -> hex): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=1100000, 7=0001111, 8=0000000, 9=0001100; 4'hF (overflow only) = 1111110. Hex is registered and updated on the same edge as the digits.
- Blanking (BLANK_ZEROS=1): digitK (K=3..1) blanked iff digitK and all higher digits are 0; digit values unaffected, only hex.
- start while busy: ignored, no queueing; numero changes during CONV have no effect.
- Back-to-back: start=1 in the done cycle (state already IDLE) is accepted; done drops next cycle, busy rises.
- Reset mid-conversion: abort, reset values, no done pulse.

Test Plan:
- Reset then idle: all digits 0, hex0..3=0000001, busy=0, done=0, overflow=0.
- start with numero=1234: busy high 14 cycles; done pulse one cycle, 14 cycles after start edge; digits 1,2,3,4; hex3..0 = 1001111, 0010010, 0000110, 1001100; overflow=0.
- numero=9999 then numero=0 back-to-back (second start in done cycle): digits 9,9,9,9 then 0,0,0,0; two done pulses 15 cycles apart.
- BLANK_ZEROS=1, numero=7: hex3..1=1111111, hex0=0001111; digits 0,0,0,7; numero=1000: no blanking, hex=1001111,0000001,0000001,0000001.
- numero=10000: after 14 cycles done=1, overflow=1, digits all 4'hF, hex all 1111110; next numero=42 clears overflow, digits 0,0,4,2.
- Edge cases:
  - start=1 on cycle 5 of a conversion with a different numero: ignored, result unchanged.
  - reset asserted on cycle 7: busy=0, no done, outputs at reset values.
